// File: rtl/cond_unit.sv
// cond_unit: banked NZCV flag registers, ARM condition evaluation, control
// strobe gating and a saturating count of condition-failed instructions.
// Build option: define COND_PIPE_EN to register CondEx, Undef, PCSrc,
// RegWrite and MemWrite (one cycle latency, held under Stall).
module cond_unit #(
  parameter int NUM_BANKS = 2,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Valid,
  input  logic                         Stall,
  input  logic [3:0]                   Cond,
  input  logic [3:0]                   ALUFlags,
  input  logic [1:0]                   FlagW,
  input  logic [$clog2(NUM_BANKS)-1:0] BankSel,
  input  logic                         PCS,
  input  logic                         RegW,
  input  logic                         MemW,
  input  logic                         ClrCount,
  output logic                         CondEx,
  output logic                         Undef,
  output logic                         PCSrc,
  output logic                         RegWrite,
  output logic                         MemWrite,
  output logic [3:0]                   Flags,
  output logic [CNT_W-1:0]             FailCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Condition field against {N,Z,C,V}; the reserved code 1111 never passes.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, ge;
    {n, z, cf, v} = f;
    ge = (n == v);
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = cf;
      4'b0011: cond_pass = ~cf;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = cf & ~z;
      4'b1001: cond_pass = ~(cf & ~z);
      4'b1010: cond_pass = ge;
      4'b1011: cond_pass = ~ge;
      4'b1100: cond_pass = ~z & ge;
      4'b1101: cond_pass = ~(~z & ge);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    sat_inc = (x == CNT_MAX) ? x : x + 1'b1;
  endfunction

  logic [3:0]       bank_q [NUM_BANKS];
  logic [CNT_W-1:0] fail_cnt_q;
  logic [31:0]      sel_ext;
  logic [3:0]       flags_p0;
  logic             vld_p0;
  logic             condex_p0;
  logic             undef_p0;
  logic             flag_we;

  // An out-of-range selector matches no bank: reads zero, writes nothing.
  assign sel_ext = 32'(BankSel);

  // Read the selected bank as it stands before this cycle's update.
  always_comb begin
    flags_p0 = 4'b0000;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (sel_ext == 32'(i)) flags_p0 = bank_q[i];
    end
  end

  assign vld_p0    = Valid & ~Stall;
  assign condex_p0 = cond_pass(Cond, flags_p0);
  assign undef_p0  = (Cond == 4'b1111);
  assign flag_we   = vld_p0 & condex_p0;
  assign Flags     = flags_p0;
  assign FailCount = fail_cnt_q;

  // Bank update: only the selected bank, N/Z and C/V halves independently.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BANKS; i++) bank_q[i] <= 4'b0000;
    end else if (flag_we) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (sel_ext == 32'(i)) begin
          if (FlagW[1]) bank_q[i][3:2] <= ALUFlags[3:2];
          if (FlagW[0]) bank_q[i][1:0] <= ALUFlags[1:0];
        end
      end
    end
  end

  // Fail counter: clear wins over count, both ignored while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      fail_cnt_q <= '0;
    end else if (!Stall && ClrCount) begin
      fail_cnt_q <= '0;
    end else if (vld_p0 && !condex_p0) begin
      fail_cnt_q <= sat_inc(fail_cnt_q);
    end
  end

`ifdef COND_PIPE_EN
  logic condex_p1, undef_p1, pcsrc_p1, regwrite_p1, memwrite_p1;

  // ---- stage p0 -> p1: registered condition result and gated strobes ----
  always_ff @(posedge clk) begin
    if (reset) begin
      condex_p1   <= 1'b0;
      undef_p1    <= 1'b0;
      pcsrc_p1    <= 1'b0;
      regwrite_p1 <= 1'b0;
      memwrite_p1 <= 1'b0;
    end else if (!Stall) begin
      condex_p1   <= condex_p0;
      undef_p1    <= undef_p0;
      pcsrc_p1    <= PCS  & condex_p0;
      regwrite_p1 <= RegW & condex_p0;
      memwrite_p1 <= MemW & condex_p0;
    end
  end

  assign CondEx   = condex_p1;
  assign Undef    = undef_p1;
  assign PCSrc    = pcsrc_p1;
  assign RegWrite = regwrite_p1;
  assign MemWrite = memwrite_p1;
`else
  assign CondEx   = condex_p0;
  assign Undef    = undef_p0;
  assign PCSrc    = PCS  & condex_p0;
  assign RegWrite = RegW & condex_p0;
  assign MemWrite = MemW & condex_p0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: scoreboard bench for cond_unit (default, combinational-output build).
// Three banks (selector value 3 is out of range) and a 4-bit fail counter.
module tb_cond_unit;

  localparam int NB = 3;
  localparam int CW = 4;

  // Field masks over obs = {CondEx, Undef, PCSrc, RegWrite, MemWrite, Flags, FailCount}
  localparam logic [12:0] M_ALL = 13'h1FFF;

  typedef struct packed {
    logic       rst;
    logic       v;
    logic       s;
    logic [3:0] c;
    logic [3:0] a;
    logic [1:0] fw;
    logic [1:0] bs;
    logic [2:0] st;
    logic       clr;
  } stim_t;

  logic          clk = 1'b0;
  logic          reset, Valid, Stall, PCS, RegW, MemW, ClrCount;
  logic [3:0]    Cond, ALUFlags;
  logic [1:0]    FlagW, BankSel;
  logic          CondEx, Undef, PCSrc, RegWrite, MemWrite;
  logic [3:0]    Flags;
  logic [CW-1:0] FailCount;
  logic [12:0]   obs;

  logic [12:0]   sb[$];
  logic [3:0]    mb[4];
  logic [3:0]    mcnt;
  int            n_checks = 0;
  int            n_fail   = 0;

  cond_unit #(.NUM_BANKS(NB), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Valid(Valid), .Stall(Stall), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .BankSel(BankSel), .PCS(PCS),
    .RegW(RegW), .MemW(MemW), .ClrCount(ClrCount), .CondEx(CondEx),
    .Undef(Undef), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .FailCount(FailCount)
  );

  always #5 clk = ~clk;

  assign obs = {CondEx, Undef, PCSrc, RegWrite, MemWrite, Flags, FailCount};

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic ge;
    ge = (f[3] == f[0]);
    case (c)
      4'h0: return f[2];
      4'h1: return !f[2];
      4'h2: return f[1];
      4'h3: return !f[1];
      4'h4: return f[3];
      4'h5: return !f[3];
      4'h6: return f[0];
      4'h7: return !f[0];
      4'h8: return f[1] && !f[2];
      4'h9: return !f[1] || f[2];
      4'hA: return ge;
      4'hB: return !ge;
      4'hC: return !f[2] && ge;
      4'hD: return f[2] || !ge;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] ref_flags();
    return (BankSel == 2'd3) ? 4'b0000 : mb[BankSel];
  endfunction

  task automatic drive(input stim_t r);
    reset = r.rst; Valid = r.v; Stall = r.s; Cond = r.c; ALUFlags = r.a;
    FlagW = r.fw; BankSel = r.bs; {PCS, RegW, MemW} = r.st; ClrCount = r.clr;
  endtask

  // Drive one cycle of stimulus and queue the outputs the model predicts for it.
  task automatic apply(input stim_t r);
    logic [3:0] f;
    logic       ce;
    drive(r);
    f  = ref_flags();
    ce = ref_cond(r.c, f);
    sb.push_back({ce, (r.c == 4'hF), r.st & {3{ce}}, f, mcnt});
    #1;
  endtask

  // Advance the model with the current inputs, then the clock.
  task automatic tick();
    logic [3:0] f;
    logic       ce;
    f  = ref_flags();
    ce = ref_cond(Cond, f);
    if (reset) begin
      for (int i = 0; i < 4; i++) mb[i] = 4'b0000;
      mcnt = 4'h0;
    end else if (!Stall) begin
      if (Valid && ce && BankSel != 2'd3) begin
        if (FlagW[1]) mb[BankSel][3:2] = ALUFlags[3:2];
        if (FlagW[0]) mb[BankSel][1:0] = ALUFlags[1:0];
      end
      if (ClrCount) mcnt = 4'h0;
      else if (Valid && !ce && mcnt != 4'hF) mcnt = mcnt + 4'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t       r[2];
    logic [12:0] km[2];
    logic [12:0] kv[2];
    logic [12:0] e;
    drive('{1'b1, 1'b1, 1'b0, 4'hE, 4'hF, 2'b11, 2'd0, 3'd7, 1'b0});
    tick();
    tick();
    r[0] = '{1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 2'd0, 3'd7, 1'b0}; km[0] = M_ALL; kv[0] = 13'h1700;
    r[1] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 2'd0, 3'd7, 1'b0}; km[1] = M_ALL; kv[1] = 13'h0000;
    for (int i = 0; i < 2; i++) begin
      apply(r[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset row %0d: got %h expected %h", i, obs, e);
      end
      n_checks++;
      if ((obs & km[i]) !== kv[i]) begin
        n_fail++;
        $display("FAIL reset_const row %0d: got %h expected %h", i, obs & km[i], kv[i]);
      end
      tick();
    end
  endtask

  task automatic test_bank();
    stim_t       r[9];
    logic [12:0] kv[9];
    logic [12:0] e;
    r[0] = '{1'b0, 1'b1, 1'b0, 4'hE, 4'h4, 2'b11, 2'd0, 3'd0, 1'b0}; kv[0] = 13'h1000;
    r[1] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 2'd0, 3'd7, 1'b0}; kv[1] = 13'h1040;
    r[2] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 2'd1, 3'd7, 1'b0}; kv[2] = 13'h0000;
    r[3] = '{1'b0, 1'b1, 1'b0, 4'hE, 4'hF, 2'b11, 2'd3, 3'd0, 1'b0}; kv[3] = 13'h1000;
    r[4] = '{1'b0, 1'b1, 1'b0, 4'hE, 4'hA, 2'b11, 2'd2, 3'd0, 1'b0}; kv[4] = 13'h1000;
    r[5] = '{1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 2'd3, 3'd0, 1'b0}; kv[5] = 13'h1000;
    r[6] = '{1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 2'd2, 3'd0, 1'b0}; kv[6] = 13'h10A0;
    r[7] = '{1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 2'd1, 3'd0, 1'b0}; kv[7] = 13'h1000;
    r[8] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 2'd0, 3'd0, 1'b0}; kv[8] = 13'h1040;
    for (int i = 0; i < 9; i++) begin
      apply(r[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL bank row %0d: got %h expected %h", i, obs, e);
      end
      n_checks++;
      if ((obs & 13'h10F0) !== kv[i]) begin
        n_fail++;
        $display("FAIL bank_const row %0d: got %h expected %h", i, obs & 13'h10F0, kv[i]);
      end
      tick();
    end
  endtask

  task automatic test_ge();
    stim_t       r[10];
    logic [12:0] kv[10];
    logic [12:0] e;
    r[0] = '{1'b0, 1'b1, 1'b0, 4'hE, 4'h9, 2'b11, 2'd0, 3'd0, 1'b0}; kv[0] = 13'h1040;
    r[1] = '{1'b0, 1'b0, 1'b0, 4'hA, 4'h0, 2'b00, 2'd0, 3'd7, 1'b0}; kv[1] = 13'h1090;
    r[2] = '{1'b0, 1'b0, 1'b0, 4'hB, 4'h0, 2'b00, 2'd0, 3'd7, 1'b0}; kv[2] = 13'h0090;
    r[3] = '{1'b0, 1'b0, 1'b0, 4'hC, 4'h0, 2'b00, 2'd0, 3'd7, 1'b0}; kv[3] = 13'h1090;
    r[4] = '{1'b0, 1'b0, 1'b0, 4'hD, 4'h0, 2'b00, 2'd0, 3'd7, 1'b0}; kv[4] = 13'h0090;
    r[5] = '{1'b0, 1'b1, 1'b0, 4'hE, 4'h4, 2'b10, 2'd0, 3'd0, 1'b0}; kv[5] = 13'h1090;
    r[6] = '{1'b0, 1'b0, 1'b0, 4'hA, 4'h0, 2'b00, 2'd0, 3'd7, 1'b0}; kv[6] = 13'h0050;
    r[7] = '{1'b0, 1'b0, 1'b0, 4'hB, 4'h0, 2'b00, 2'd0, 3'd7, 1'b0}; kv[7] = 13'h1050;
    r[8] = '{1'b0, 1'b0, 1'b0, 4'hC, 4'h0, 2'b00, 2'd0, 3'd7, 1'b0}; kv[8] = 13'h0050;
    r[9] = '{1'b0, 1'b0, 1'b0, 4'hD, 4'h0, 2'b00, 2'd0, 3'd7, 1'b0}; kv[9] = 13'h1050;
    for (int i = 0; i < 10; i++) begin
      apply(r[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL ge row %0d: got %h expected %h", i, obs, e);
      end
      n_checks++;
      if ((obs & 13'h10F0) !== kv[i]) begin
        n_fail++;
        $display("FAIL ge_const row %0d: got %h expected %h", i, obs & 13'h10F0, kv[i]);
      end
      tick();
    end
  endtask

  task automatic test_undef();
    stim_t       r[2];
    logic [12:0] kv[2];
    logic [12:0] e;
    r[0] = '{1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 2'b11, 2'd0, 3'd7, 1'b0}; kv[0] = 13'h0850;
    r[1] = '{1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 2'd0, 3'd0, 1'b0}; kv[1] = 13'h1051;
    for (int i = 0; i < 2; i++) begin
      apply(r[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL undef row %0d: got %h expected %h", i, obs, e);
      end
      n_checks++;
      if (obs !== kv[i]) begin
        n_fail++;
        $display("FAIL undef_const row %0d: got %h expected %h", i, obs, kv[i]);
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    stim_t       r[24];
    logic [3:0]  kc[24];
    logic        kon[24];
    logic [12:0] e;
    for (int i = 0; i < 20; i++) begin
      r[i]   = '{1'b0, 1'b1, 1'b0, (i % 2 == 1) ? 4'hF : 4'h0, 4'hF, 2'b11, 2'd1, 3'd7, 1'b0};
      kon[i] = 1'b0;
      kc[i]  = 4'h0;
    end
    r[20] = '{1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 2'd1, 3'd0, 1'b1}; kon[20] = 1'b0; kc[20] = 4'h0;
    r[20].s = 1'b1;
    r[21] = '{1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 2'd1, 3'd0, 1'b0}; kon[21] = 1'b1; kc[21] = 4'hF;
    r[22] = '{1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 2'd1, 3'd0, 1'b1}; kon[22] = 1'b1; kc[22] = 4'hF;
    r[23] = '{1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 2'd1, 3'd0, 1'b0}; kon[23] = 1'b1; kc[23] = 4'h0;
    for (int i = 0; i < 24; i++) begin
      apply(r[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL saturate row %0d: got %h expected %h", i, obs, e);
      end
      if (kon[i]) begin
        n_checks++;
        if (FailCount !== kc[i]) begin
          n_fail++;
          $display("FAIL saturate_count row %0d: got %0d expected %0d", i, FailCount, kc[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    stim_t       r[3];
    logic [12:0] km[3];
    logic [12:0] kv[3];
    logic [12:0] e;
    r[0] = '{1'b0, 1'b1, 1'b1, 4'hE, 4'hF, 2'b11, 2'd0, 3'd7, 1'b0}; km[0] = 13'h17F0; kv[0] = 13'h1750;
    r[1] = '{1'b0, 1'b1, 1'b1, 4'hF, 4'h0, 2'b11, 2'd0, 3'd0, 1'b0}; km[1] = 13'h00FF; kv[1] = 13'h0050;
    r[2] = '{1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 2'd0, 3'd0, 1'b0}; km[2] = 13'h00FF; kv[2] = 13'h0050;
    for (int i = 0; i < 3; i++) begin
      apply(r[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL stall row %0d: got %h expected %h", i, obs, e);
      end
      n_checks++;
      if ((obs & km[i]) !== kv[i]) begin
        n_fail++;
        $display("FAIL stall_const row %0d: got %h expected %h", i, obs & km[i], kv[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    stim_t       r[8];
    logic [12:0] kv[8];
    logic [12:0] e;
    r[0] = '{1'b0, 1'b1, 1'b0, 4'hE, 4'hF, 2'b11, 2'd1, 3'd0, 1'b0}; kv[0] = 13'h0000;
    r[1] = '{1'b0, 1'b1, 1'b0, 4'h1, 4'h0, 2'b11, 2'd1, 3'd0, 1'b0}; kv[1] = 13'h00F0;
    r[2] = '{1'b0, 1'b1, 1'b0, 4'h1, 4'h0, 2'b11, 2'd1, 3'd0, 1'b0}; kv[2] = 13'h00F1;
    r[3] = '{1'b1, 1'b1, 1'b1, 4'hE, 4'hF, 2'b11, 2'd0, 3'd0, 1'b1}; kv[3] = 13'h0052;
    r[4] = '{1'b1, 1'b1, 1'b0, 4'hE, 4'hF, 2'b11, 2'd2, 3'd0, 1'b0}; kv[4] = 13'h0000;
    r[5] = '{1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 2'd0, 3'd0, 1'b0}; kv[5] = 13'h0000;
    r[6] = '{1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 2'd1, 3'd0, 1'b0}; kv[6] = 13'h0000;
    r[7] = '{1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 2'd2, 3'd0, 1'b0}; kv[7] = 13'h0000;
    for (int i = 0; i < 8; i++) begin
      apply(r[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid row %0d: got %h expected %h", i, obs, e);
      end
      if (i > 0) begin
        n_checks++;
        if ((obs & 13'h00FF) !== kv[i]) begin
          n_fail++;
          $display("FAIL reset_mid_const row %0d: got %h expected %h", i, obs & 13'h00FF, kv[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    stim_t       r;
    logic [12:0] e;
    for (int i = 0; i < 300; i++) begin
      r.rst = 1'b0;
      r.v   = ($urandom_range(0, 3) != 0);
      r.s   = ($urandom_range(0, 4) == 0);
      r.c   = 4'($urandom);
      r.a   = 4'($urandom);
      r.fw  = 2'($urandom);
      r.bs  = 2'($urandom);
      r.st  = 3'($urandom);
      r.clr = ($urandom_range(0, 15) == 0);
      apply(r);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h (cond %h bank %0d)",
                 i, obs, e, r.c, r.bs);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mb[i] = 4'b0000;
    mcnt = 4'h0;
    drive('{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 2'd0, 3'd0, 1'b0});
    test_reset();
    test_bank();
    test_ge();
    test_undef();
    test_saturate();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
